relay_credit_tx: RTL

Credit-based transmitter for the pipelined FIFO link used between floorplan regions. It pops words from a local first-word fall-through FIFO and drives them onto a registered forward link. It fires a word only while it holds a credit, so the far-end buffer never needs an almost-full grace margin. Credits come back as one pulse per word popped at the receiver. The block sits at the source end of a relay path, and the receiving buffer sits at the sink end.

---
 rtl/relay_pkg.sv | 12 +
 rtl/relay_credit_tx_if.sv | 21 ++
 rtl/relay_pipe_reg.sv | 38 +++
 rtl/relay_credit_tx.sv | 83 ++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared constants for the relay credit link (transmitter and receiving buffer).
package relay_pkg;

    localparam int unsigned RELAY_CREDITS   = 8;
    localparam int unsigned RELAY_RET_LEVEL = 2;

    // Counter must represent 0..credits inclusive.
    function automatic int unsigned relay_cnt_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/relay_credit_tx_if.sv
// Upstream FIFO, forward link and credit return signals of the relay transmitter.
interface relay_credit_tx_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_empty_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  link_valid;
    logic [DATA_WIDTH-1:0] link_data;
    logic                  credit_ret;

    modport master (
        input  if_empty_n, if_din, credit_ret,
        output if_read, link_valid, link_data
    );

    modport slave (
        output if_empty_n, if_din, credit_ret,
        input  if_read, link_valid, link_data
    );
endinterface

// File: rtl/relay_pipe_reg.sv
// 1-bit register chain with synchronous clear; DEPTH = 0 degenerates to a wire.
module relay_pipe_reg #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic i_clr_n,
    input  logic i_d,
    output logic o_q,
    output logic o_busy
);
    if (DEPTH == 0) begin : g_wire
        assign o_q    = i_d;
        assign o_busy = 1'b0;
    end else begin : g_chain
        logic [DEPTH-1:0] w_bits;

        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            (* dont_touch = "true" *) logic r_q;
            logic w_in;

            if (i == 0) begin : g_first
                assign w_in = i_d;
            end else begin : g_next
                assign w_in = w_bits[i-1];
            end

            always_ff @(posedge clk) begin
                if (!i_clr_n) r_q <= 1'b0;
                else          r_q <= w_in;
            end

            assign w_bits[i] = r_q;
        end

        assign o_q    = w_bits[DEPTH-1];
        assign o_busy = |w_bits;
    end
endmodule

// File: rtl/relay_credit_tx.sv
// Credit-based relay transmitter: pops a FWFT FIFO onto a registered link while credits remain.
// Optional sticky over-return detection is enabled by defining RELAY_CREDIT_CHECK_EN.
module relay_credit_tx
    import relay_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned CREDITS    = RELAY_CREDITS,
    parameter  int unsigned RET_LEVEL  = RELAY_RET_LEVEL,
    localparam int unsigned CNT_WIDTH  = relay_cnt_width(CREDITS)
) (
    input  logic                 clk,
    input  logic                 ap_rst_n,
    relay_credit_tx_if.master    bus,
    output logic [CNT_WIDTH-1:0] credits_avail,
    output logic                 idle,
    output logic                 credit_err
);
    localparam int unsigned          SUM_W   = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CREDITS);

    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_link_valid;
    logic [DATA_WIDTH-1:0] r_link_data;
    logic                  w_fire;
    logic                  w_ret_d;
    logic                  w_pipe_busy;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_sat;

    relay_pipe_reg #(
        .DEPTH (RET_LEVEL)
    ) u_ret_pipe (
        .clk     (clk),
        .i_clr_n (ap_rst_n),
        .i_d     (bus.credit_ret),
        .o_q     (w_ret_d),
        .o_busy  (w_pipe_busy)
    );

    // Fire looks only at the registered count; a same-cycle return cannot enable it.
    assign w_fire = ap_rst_n & bus.if_empty_n & (r_cnt != '0);
    assign w_sum  = SUM_W'(r_cnt) - SUM_W'(w_fire) + SUM_W'(w_ret_d);
    assign w_sat  = (w_sum > SUM_W'(CREDITS));

    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            r_cnt        <= CNT_MAX;
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
        end else begin
            r_cnt        <= w_sat ? CNT_MAX : w_sum[CNT_WIDTH-1:0];
            r_link_valid <= w_fire;
            if (w_fire) r_link_data <= bus.if_din;
        end
    end

    assign bus.if_read    = w_fire;
    assign bus.link_valid = r_link_valid;
    assign bus.link_data  = r_link_data;
    assign credits_avail  = r_cnt;
    assign idle           = (r_cnt == CNT_MAX) & ~w_pipe_busy;

`ifdef RELAY_CREDIT_CHECK_EN
    logic r_credit_err;

    always_ff @(posedge clk) begin
        if (!ap_rst_n)  r_credit_err <= 1'b0;
        else if (w_sat) r_credit_err <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (ap_rst_n && w_sat && !r_credit_err)
            $error("relay_credit_tx: credit returned while count already at maximum");
    end
`endif

    assign credit_err = r_credit_err;
`else
    assign credit_err = 1'b0;
`endif

endmodule
